// File: rtl/axis_len_stamp_pkg.sv
// Shared types and header layout for the length-stamping store-and-forward framer.
package axis_len_stamp_pkg;

  localparam int unsigned OVF_BIT = 15;
  localparam int unsigned LEN_MSB = 14;

`ifdef AXIS_LEN_STAMP_TRAILER_EN
  typedef enum logic [1:0] {StFill, StHead, StData, StTrail} state_e;
`else
  typedef enum logic [1:0] {StFill, StHead, StData} state_e;
`endif

  function automatic logic [15:0] hdr_word(input logic ovf, input logic [LEN_MSB:0] len);
    logic [15:0] w;
    w = '0;
    w[OVF_BIT] = ovf;
    w[LEN_MSB:0] = len;
    return w;
  endfunction

endpackage

// File: rtl/axis_len_stamp_ram.sv
// Simple dual-port packet buffer: one write port, registered read port, array not reset.
module axis_len_stamp_ram #(
  parameter int unsigned Depth = 64,
  parameter int unsigned Width = 16,
  parameter int unsigned Aw    = 6
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [Aw-1:0]    waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [Aw-1:0]    raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axis_len_stamp.sv
// Store-and-forward framer: buffers one packet, emits {ovf, len} header then the payload.
// Define AXIS_LEN_STAMP_TRAILER_EN to append an XOR-of-payload trailer word.
module axis_len_stamp #(
  parameter int unsigned DSIZE = 16,
  parameter int unsigned DEPTH = 64
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             in_tvalid_i,
  output logic             in_tready_o,
  input  logic [DSIZE-1:0] in_tdata_i,
  input  logic             in_tuser_i,
  input  logic             in_tlast_i,
  output logic             out_tvalid_o,
  input  logic             out_tready_i,
  output logic [DSIZE-1:0] out_tdata_o,
  output logic             out_tuser_o,
  output logic             out_tlast_o,
  output logic [31:0]      pkt_cnt_o,
  output logic [15:0]      ovf_cnt_o
);
  import axis_len_stamp_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  state_e           state_q, state_d;
  logic             in_tready_q;
  logic [LW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    len_q, len_d;
  logic             ovf_q, ovf_d;
  logic [31:0]      pkt_cnt_q, pkt_cnt_d;
  logic [15:0]      ovf_cnt_q, ovf_cnt_d;
`ifdef AXIS_LEN_STAMP_TRAILER_EN
  logic [DSIZE-1:0] xor_q, xor_d;
`endif

  logic             in_fire, out_fire, full, last_word, pkt_done, ram_we;
  logic [AW-1:0]    raddr;
  logic [DSIZE-1:0] rdata;
  logic             unused_tuser;

  assign unused_tuser = in_tuser_i;

  assign in_fire   = in_tvalid_i & in_tready_q;
  assign out_fire  = out_tvalid_o & out_tready_i;
  assign full      = wr_ptr_q[AW];
  assign last_word = ({1'b0, rd_ptr_q} == (len_q - LW'(1)));
  assign ram_we    = in_fire & ~full;

  axis_len_stamp_ram #(
    .Depth (DEPTH),
    .Width (DSIZE),
    .Aw    (AW)
  ) u_ram (
    .clk_i   (clock),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (in_tdata_i),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    len_d        = len_q;
    ovf_d        = ovf_q;
    pkt_cnt_d    = pkt_cnt_q;
    ovf_cnt_d    = ovf_cnt_q;
`ifdef AXIS_LEN_STAMP_TRAILER_EN
    xor_d        = xor_q;
`endif
    pkt_done     = 1'b0;
    // Read address runs one word ahead on a handshake so the RAM output is already valid
    raddr        = rd_ptr_q;
    out_tvalid_o = 1'b0;
    out_tdata_o  = '0;
    out_tuser_o  = 1'b0;
    out_tlast_o  = 1'b0;

    unique case (state_q)
      StFill: begin
        if (in_fire) begin
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            wr_ptr_d = wr_ptr_q + LW'(1);
`ifdef AXIS_LEN_STAMP_TRAILER_EN
            xor_d    = xor_q ^ in_tdata_i;
`endif
          end
          if (in_tlast_i) begin
            len_d   = full ? wr_ptr_q : wr_ptr_q + LW'(1);
            state_d = StHead;
          end
        end
      end
      StHead: begin
        out_tvalid_o = 1'b1;
        out_tdata_o  = hdr_word(ovf_q, 15'(len_q));
        out_tuser_o  = 1'b1;
        if (out_fire) begin
          state_d = StData;
        end
      end
      StData: begin
        out_tvalid_o = 1'b1;
        out_tdata_o  = rdata;
`ifndef AXIS_LEN_STAMP_TRAILER_EN
        out_tlast_o  = last_word;
`endif
        if (out_fire) begin
          raddr    = rd_ptr_q + AW'(1);
          rd_ptr_d = rd_ptr_q + AW'(1);
          if (last_word) begin
`ifdef AXIS_LEN_STAMP_TRAILER_EN
            state_d  = StTrail;
`else
            state_d  = StFill;
            pkt_done = 1'b1;
`endif
          end
        end
      end
`ifdef AXIS_LEN_STAMP_TRAILER_EN
      StTrail: begin
        out_tvalid_o = 1'b1;
        out_tdata_o  = xor_q;
        out_tlast_o  = 1'b1;
        if (out_fire) begin
          state_d  = StFill;
          pkt_done = 1'b1;
        end
      end
`endif
      default: state_d = StFill;
    endcase

    if (pkt_done) begin
      pkt_cnt_d = pkt_cnt_q + 32'd1;
      if (ovf_q && (ovf_cnt_q != 16'hFFFF)) begin
        ovf_cnt_d = ovf_cnt_q + 16'd1;
      end
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
`ifdef AXIS_LEN_STAMP_TRAILER_EN
      xor_d    = '0;
`endif
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StFill;
      in_tready_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      len_q       <= '0;
      ovf_q       <= 1'b0;
      pkt_cnt_q   <= '0;
      ovf_cnt_q   <= '0;
`ifdef AXIS_LEN_STAMP_TRAILER_EN
      xor_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      in_tready_q <= (state_d == StFill);
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      len_q       <= len_d;
      ovf_q       <= ovf_d;
      pkt_cnt_q   <= pkt_cnt_d;
      ovf_cnt_q   <= ovf_cnt_d;
`ifdef AXIS_LEN_STAMP_TRAILER_EN
      xor_q       <= xor_d;
`endif
    end
  end

  assign in_tready_o = in_tready_q;
  assign pkt_cnt_o   = pkt_cnt_q;
  assign ovf_cnt_o   = ovf_cnt_q;

endmodule

// File: tb/tb_axis_len_stamp.sv
// Directed self-checking bench for axis_len_stamp; output beats are packed as {tuser, tlast, tdata}.
module tb_axis_len_stamp;

  localparam int unsigned DEPTH = 64;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_tvalid = 1'b0, in_tready, in_tuser = 1'b0, in_tlast = 1'b0;
  logic [15:0] in_tdata = '0;
  logic        out_tvalid, out_tready = 1'b0, out_tuser, out_tlast;
  logic [15:0] out_tdata;
  logic [31:0] pkt_cnt;
  logic [15:0] ovf_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] tx_q[$];
  logic [17:0] rx_q[$];
  logic [17:0] exp_q[$];
  int          rx_cycles, tx_waits, stall_viol;

  always #5 clock = ~clock;

  axis_len_stamp #(
    .DSIZE (16),
    .DEPTH (DEPTH)
  ) dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .in_tvalid_i  (in_tvalid),
    .in_tready_o  (in_tready),
    .in_tdata_i   (in_tdata),
    .in_tuser_i   (in_tuser),
    .in_tlast_i   (in_tlast),
    .out_tvalid_o (out_tvalid),
    .out_tready_i (out_tready),
    .out_tdata_o  (out_tdata),
    .out_tuser_o  (out_tuser),
    .out_tlast_o  (out_tlast),
    .pkt_cnt_o    (pkt_cnt),
    .ovf_cnt_o    (ovf_cnt)
  );

  // Drive tx_q as one packet; returns at the negedge after the tlast handshake.
  task automatic send();
    int n;
    tx_waits = 0;
    foreach (tx_q[i]) begin
      @(negedge clock);
      in_tvalid = 1'b1;
      in_tdata  = tx_q[i];
      in_tlast  = (i == tx_q.size() - 1);
      in_tuser  = 1'($urandom_range(0, 1));
      n = 0;
      while (!in_tready && n < 200) begin
        @(negedge clock);
        n++;
      end
      tx_waits += n;
      if (n >= 200) break;
    end
    @(negedge clock);
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
  endtask

  // Collect one output packet; must be entered at a negedge.
  task automatic receive(input bit rand_rdy);
    logic [17:0] cur, prev;
    logic        prev_stall, done;
    rx_q.delete();
    stall_viol = 0;
    rx_cycles  = 0;
    prev_stall = 1'b0;
    prev       = '0;
    for (int n = 0; n < 3000; n++) begin
      cur = {out_tuser, out_tlast, out_tdata};
      if (prev_stall && (!out_tvalid || cur !== prev)) stall_viol++;
      out_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      rx_cycles++;
      if (out_tvalid && out_tready) rx_q.push_back(cur);
      prev_stall = out_tvalid && !out_tready;
      prev       = cur;
      done       = out_tvalid && out_tready && out_tlast;
      @(negedge clock);
      if (done) break;
    end
    out_tready = 1'b0;
  endtask

  // Reference framing of tx_q.
  task automatic build_exp();
    int          n, len;
    logic        ovf;
    logic [15:0] x;
    n   = tx_q.size();
    len = (n > DEPTH) ? DEPTH : n;
    ovf = (n > DEPTH);
    x   = '0;
    exp_q.delete();
    exp_q.push_back({1'b1, 1'b0, ovf, 15'(len)});
    for (int i = 0; i < len; i++) begin
      x ^= tx_q[i];
`ifdef AXIS_LEN_STAMP_TRAILER_EN
      exp_q.push_back({1'b0, 1'b0, tx_q[i]});
`else
      exp_q.push_back({1'b0, (i == len - 1), tx_q[i]});
`endif
    end
`ifdef AXIS_LEN_STAMP_TRAILER_EN
    exp_q.push_back({2'b01, x});
`endif
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    checks++;
    if ({in_tready, out_tvalid, out_tdata, out_tlast, out_tuser} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy/vld/data/last/user=%h, expected 0",
               {in_tready, out_tvalid, out_tdata, out_tlast, out_tuser});
    end
    checks++;
    if ({pkt_cnt, ovf_cnt} !== 48'h0) begin
      errors++;
      $display("FAIL reset_counters: got pkt=%0d ovf=%0d, expected 0/0", pkt_cnt, ovf_cnt);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_tready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_ready: got %b before first edge, expected 0", in_tready);
    end
    @(negedge clock);
    checks++;
    if (in_tready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b, expected 1", in_tready);
    end
  endtask

  task automatic test_single();
    tx_q.delete();
    for (int i = 1; i <= 4; i++) tx_q.push_back(16'(i));
    exp_q.delete();
    exp_q.push_back(18'h2_0004);
    exp_q.push_back(18'h0_0001);
    exp_q.push_back(18'h0_0002);
    exp_q.push_back(18'h0_0003);
`ifdef AXIS_LEN_STAMP_TRAILER_EN
    exp_q.push_back(18'h0_0004);
    exp_q.push_back(18'h1_0004);
`else
    exp_q.push_back(18'h1_0004);
`endif
    send();
    receive(1'b0);
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL single_len: got %0d beats, expected %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL single_word%0d: got %h, expected %h", i, rx_q[i], exp_q[i]);
      end
    end
    checks++;
    if (rx_cycles != exp_q.size()) begin
      errors++;
      $display("FAIL single_backtoback: got %0d cycles, expected %0d", rx_cycles, exp_q.size());
    end
    checks++;
    if (pkt_cnt !== 32'd1) begin
      errors++;
      $display("FAIL single_pkt_cnt: got %0d, expected 1", pkt_cnt);
    end
  endtask

  task automatic test_one_beat();
    tx_q.delete();
    tx_q.push_back(16'hBEEF);
    exp_q.delete();
    exp_q.push_back(18'h2_0001);
`ifdef AXIS_LEN_STAMP_TRAILER_EN
    exp_q.push_back(18'h0_BEEF);
    exp_q.push_back(18'h1_BEEF);
`else
    exp_q.push_back(18'h1_BEEF);
`endif
    send();
    receive(1'b0);
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL one_beat_len: got %0d beats, expected %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL one_beat_word%0d: got %h, expected %h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_overflow();
    tx_q.delete();
    for (int i = 0; i < 70; i++) tx_q.push_back(16'(16'h0100 + i));
    build_exp();
    send();
    checks++;
    if (tx_waits != 0) begin
      errors++;
      $display("FAIL ovf_in_ready: got %0d stall cycles, expected 0", tx_waits);
    end
    receive(1'b0);
    checks++;
    if (rx_q.size() == 0 || rx_q[0] !== 18'h2_8040) begin
      errors++;
      $display("FAIL ovf_header: got %h, expected 28040", (rx_q.size() != 0) ? rx_q[0] : 18'h0);
    end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL ovf_len: got %0d beats, expected %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL ovf_word%0d: got %h, expected %h", i, rx_q[i], exp_q[i]);
      end
    end
    checks++;
    if (ovf_cnt !== 16'd1 || pkt_cnt !== 32'd3) begin
      errors++;
      $display("FAIL ovf_counters: got ovf=%0d pkt=%0d, expected 1/3", ovf_cnt, pkt_cnt);
    end
  endtask

  task automatic test_random_backpressure();
    for (int p = 0; p < 20; p++) begin
      tx_q.delete();
      for (int i = 0; i < int'($urandom_range(1, 64)); i++) tx_q.push_back(16'($urandom));
      build_exp();
      send();
      receive(1'b1);
      checks++;
      if (rx_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL rand%0d_len: got %0d beats, expected %0d", p, rx_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rand%0d_word%0d: got %h, expected %h", p, i, rx_q[i], exp_q[i]);
        end
      end
      checks++;
      if (stall_viol != 0) begin
        errors++;
        $display("FAIL rand%0d_stable: got %0d unstable stalls, expected 0", p, stall_viol);
      end
    end
    checks++;
    if (pkt_cnt !== 32'd23 || ovf_cnt !== 16'd1) begin
      errors++;
      $display("FAIL rand_counters: got pkt=%0d ovf=%0d, expected 23/1", pkt_cnt, ovf_cnt);
    end
  endtask

`ifdef AXIS_LEN_STAMP_TRAILER_EN
  task automatic test_trailer();
    tx_q.delete();
    tx_q.push_back(16'h00F0);
    tx_q.push_back(16'h0F0F);
    exp_q.delete();
    exp_q.push_back(18'h2_0002);
    exp_q.push_back(18'h0_00F0);
    exp_q.push_back(18'h0_0F0F);
    exp_q.push_back(18'h1_0FFF);
    send();
    receive(1'b0);
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL trailer_len: got %0d beats, expected %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL trailer_word%0d: got %h, expected %h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask
`endif

  task automatic test_reset_mid();
    tx_q.delete();
    for (int i = 0; i < 10; i++) tx_q.push_back(16'(16'h0A00 + i));
    send();
    out_tready = 1'b1;
    repeat (4) @(negedge clock);
    out_tready = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_tready, out_tvalid, out_tdata, out_tlast, out_tuser} !== 20'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h, expected 0",
               {in_tready, out_tvalid, out_tdata, out_tlast, out_tuser});
    end
    checks++;
    if ({pkt_cnt, ovf_cnt} !== 48'h0) begin
      errors++;
      $display("FAIL midreset_counters: got pkt=%0d ovf=%0d, expected 0/0", pkt_cnt, ovf_cnt);
    end
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    tx_q.delete();
    tx_q.push_back(16'h00AA);
    exp_q.delete();
    exp_q.push_back(18'h2_0001);
`ifdef AXIS_LEN_STAMP_TRAILER_EN
    exp_q.push_back(18'h0_00AA);
    exp_q.push_back(18'h1_00AA);
`else
    exp_q.push_back(18'h1_00AA);
`endif
    send();
    receive(1'b0);
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL midreset_len: got %0d beats, expected %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL midreset_word%0d: got %h, expected %h", i, rx_q[i], exp_q[i]);
      end
    end
    checks++;
    if (pkt_cnt !== 32'd1) begin
      errors++;
      $display("FAIL midreset_pkt_cnt: got %0d, expected 1", pkt_cnt);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_one_beat();
    test_overflow();
    test_random_backpressure();
`ifdef AXIS_LEN_STAMP_TRAILER_EN
    test_trailer();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
